// File: rtl/mosaic_pkg.sv
// Shared types and width helpers for the mosaic block-matching sequencer.
package mosaic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int SCORE_W_DEF = 16;

  typedef logic [SCORE_W_DEF-1:0] score_t;

  localparam score_t SCORE_MAX = '1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int off_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_offset_counter.sv
// Row/column raster counter over a ROWS x COLS grid with clear, advance and last flag.
module raster_offset_counter #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/match_scan_ctrl.sv
// Block-matching sequencer: issues one engine request per legal POI offset in
// raster order, tracks the minimum SAD score and reports completion or timeout.
module match_scan_ctrl
  import mosaic_pkg::*;
#(
  parameter int ROI_DEPTH = 6,
  parameter int ROI_WIDTH = 6,
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int TIMEOUT   = 255,
  localparam int RW = off_w(ROI_DEPTH - POI_DEPTH + 1),
  localparam int CW = off_w(ROI_WIDTH - POI_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               status,
  output logic               err,
  output logic               eng_start,
  output logic [RW-1:0]      eng_row_off,
  output logic [CW-1:0]      eng_col_off,
  input  logic               eng_done,
  input  logic [SCORE_W-1:0] eng_score,
  output logic [RW-1:0]      best_row,
  output logic [CW-1:0]      best_col,
  output logic [SCORE_W-1:0] best_score
);

  localparam int N_ROWS = ROI_DEPTH - POI_DEPTH + 1;
  localparam int N_COLS = ROI_WIDTH - POI_WIDTH + 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  if (POI_DEPTH > ROI_DEPTH) begin : g_bad_depth
    $error("match_scan_ctrl: POI_DEPTH must not exceed ROI_DEPTH");
  end
  if (POI_WIDTH > ROI_WIDTH) begin : g_bad_width
    $error("match_scan_ctrl: POI_WIDTH must not exceed ROI_WIDTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("match_scan_ctrl: TIMEOUT must be at least 1");
  end

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               status_q, status_d;
  logic               err_q, err_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [TW-1:0]      timer_inc;
  logic [RW-1:0]      best_row_q, best_row_d;
  logic [CW-1:0]      best_col_q, best_col_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;

  logic          cnt_clear;
  logic          cnt_adv;
  logic          cnt_last;
  logic [RW-1:0] cnt_row;
  logic [CW-1:0] cnt_col;

  raster_offset_counter #(
    .ROWS (N_ROWS),
    .COLS (N_COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_offset_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .row     (cnt_row),
    .col     (cnt_col),
    .last    (cnt_last)
  );

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    status_d     = status_q;
    err_d        = err_q;
    timer_d      = timer_q;
    best_row_d   = best_row_q;
    best_col_d   = best_col_q;
    best_score_d = best_score_q;
    cnt_clear    = 1'b0;
    cnt_adv      = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          status_d     = 1'b0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          cnt_clear    = 1'b1;
          best_score_d = '1;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (eng_done) begin
          // Strict compare: a tie leaves the earlier raster position in place.
          if (eng_score < best_score_q) begin
            best_score_d = eng_score;
            best_row_d   = cnt_row;
            best_col_d   = cnt_col;
          end
          if (cnt_last) begin
            done_d   = 1'b1;
            status_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_FIN;
          end else begin
            cnt_adv = 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc >= TMR_LAST) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_ERR;
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= 1'b0;
      err_q        <= 1'b0;
      timer_q      <= '0;
      best_row_q   <= '0;
      best_col_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      status_q     <= status_d;
      err_q        <= err_d;
      timer_q      <= timer_d;
      best_row_q   <= best_row_d;
      best_col_q   <= best_col_d;
      best_score_q <= best_score_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign status      = status_q;
  assign err         = err_q;
  assign eng_start   = (state_q == ST_ISSUE);
  assign eng_row_off = cnt_row;
  assign eng_col_off = cnt_col;
  assign best_row    = best_row_q;
  assign best_col    = best_col_q;
  assign best_score  = best_score_q;

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Randomized bench for match_scan_ctrl with a raster-index reference model.
module tb_match_scan_ctrl;

  localparam int NR   = 3;
  localparam int NC   = 3;
  localparam int NPOS = NR * NC;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, eng_done;
  logic [15:0] eng_score;
  logic        busy, done, status, err, eng_start;
  logic [1:0]  eng_row_off, eng_col_off, best_row, best_col;
  logic [15:0] best_score;

  logic        start1, eng_done1;
  logic [15:0] eng_score1;
  logic        busy1, done1, status1, err1, eng_start1;
  logic        eng_row_off1, eng_col_off1, best_row1, best_col1;
  logic [15:0] best_score1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_eng_start  = 0;
  int n_done       = 0;
  int n_eng_start1 = 0;

  int          sc [NPOS];
  logic [15:0] m_best_score;
  int          m_best_row, m_best_col;

  always #5 clk = ~clk;

  match_scan_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .status(status), .err(err), .eng_start(eng_start),
    .eng_row_off(eng_row_off), .eng_col_off(eng_col_off),
    .eng_done(eng_done), .eng_score(eng_score),
    .best_row(best_row), .best_col(best_col), .best_score(best_score)
  );

  match_scan_ctrl #(
    .ROI_DEPTH(4), .ROI_WIDTH(4), .POI_DEPTH(4), .POI_WIDTH(4)
  ) u_one (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .status(status1), .err(err1), .eng_start(eng_start1),
    .eng_row_off(eng_row_off1), .eng_col_off(eng_col_off1),
    .eng_done(eng_done1), .eng_score(eng_score1),
    .best_row(best_row1), .best_col(best_col1), .best_score(best_score1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_start)  n_eng_start  <= n_eng_start + 1;
    if (done)       n_done       <= n_done + 1;
    if (eng_start1) n_eng_start1 <= n_eng_start1 + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic wait_eng_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (eng_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: first strictly-smaller score wins; position from raster index.
  task automatic model_score(input int idx, input int s);
    if (16'(s) < m_best_score) begin
      m_best_score = 16'(s);
      m_best_row   = idx / NC;
      m_best_col   = idx % NC;
    end
  endtask

  task automatic run_scan(input int hang_idx, input int extra_idx, input int rst_idx, input bit fixed_delay);
    int c0, ck, d, starts0, done0;
    bit ok;
    starts0 = n_eng_start;
    done0   = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
    m_best_score = 16'hFFFF;
    for (int i = 0; i < NPOS; i++) begin
      wait_eng_start(ok);
      if (!ok) begin
        check_val("eng_start_seen", 32'(ok), 32'd1);
        return;
      end
      ck = cyc;
      if (i == 0) begin
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("err_cleared", 32'(err), 32'd0);
        check_val("status_cleared", 32'(status), 32'd0);
      end
      check_val("row_off", 32'(eng_row_off), 32'(i / NC));
      check_val("col_off", 32'(eng_col_off), 32'(i % NC));
      if (i == rst_idx) begin
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_status", 32'(status), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_eng_start", 32'(eng_start), 32'd0);
        check_val("rst_offs", 32'({eng_row_off, eng_col_off}), 32'd0);
        check_val("rst_best", 32'({best_row, best_col, best_score}), 32'd0);
        @(negedge clk); reset = 1'b0;
        m_best_score = '0; m_best_row = 0; m_best_col = 0;
        repeat (3) @(negedge clk);
        check_val("rst_no_done", 32'(n_done), 32'(done0));
        return;
      end
      if (i == hang_idx) begin
        while (cyc < ck + TMO - 1) @(negedge clk);
        check_val("err_not_yet", 32'(err), 32'd0);
        @(negedge clk);
        check_val("err_at_timeout", 32'(err), 32'd1);
        check_val("err_busy", 32'(busy), 32'd0);
        check_val("err_best_score", 32'(best_score), 32'(m_best_score));
        check_val("err_best_pos", 32'({best_row, best_col}), 32'((m_best_row << 2) | m_best_col));
        @(negedge clk);
        check_val("err_no_done", 32'(n_done), 32'(done0));
        return;
      end
      d = fixed_delay ? 1 : int'($urandom_range(1, 4));
      if (i == extra_idx) d = 3;
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        start = (i == extra_idx && k == 0);
      end
      eng_done  = 1'b1;
      eng_score = 16'(sc[i]);
      model_score(i, sc[i]);
      @(posedge clk); #1 eng_done = 1'b0;
    end
    @(negedge clk);
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("status_set", 32'(status), 32'd1);
    check_val("busy_clear", 32'(busy), 32'd0);
    check_val("best_score", 32'(best_score), 32'(m_best_score));
    check_val("best_row", 32'(best_row), 32'(m_best_row));
    check_val("best_col", 32'(best_col), 32'(m_best_col));
    if (fixed_delay) check_val("scan_cycles", 32'(cyc - c0), 32'd18);
    @(negedge clk);
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("status_held", 32'(status), 32'd1);
    check_val("eng_start_count", 32'(n_eng_start - starts0), 32'(NPOS));
  endtask

  task automatic rand_scores(input int hi);
    for (int i = 0; i < NPOS; i++) sc[i] = int'($urandom_range(0, hi));
  endtask

  initial begin
    int one_seen;
    reset = 1'b1; start = 1'b0; eng_done = 1'b0; eng_score = '0;
    start1 = 1'b0; eng_done1 = 1'b0; eng_score1 = '0;
    m_best_score = '0; m_best_row = 0; m_best_col = 0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'({busy, done, status, err, eng_start}), 32'd0);
    check_val("reset_best", 32'({best_row, best_col, best_score}), 32'd0);
    reset = 1'b0;

    sc = '{50, 40, 30, 20, 10, 60, 70, 80, 90};
    run_scan(-1, -1, -1, 1'b1);
    check_val("directed_best_score", 32'(best_score), 32'd10);

    sc = '{25, 25, 25, 25, 25, 25, 25, 25, 25};
    run_scan(-1, -1, -1, 1'b1);

    rand_scores(1000);
    run_scan(1, -1, -1, 1'b0);

    rand_scores(40);
    run_scan(-1, -1, -1, 1'b0);

    rand_scores(40);
    run_scan(-1, 2, -1, 1'b0);

    rand_scores(500);
    run_scan(-1, -1, 4, 1'b0);
    rand_scores(500);
    run_scan(-1, -1, -1, 1'b1);

    // A stray engine answer while idle must not disturb the held result.
    @(posedge clk); #1 eng_done = 1'b1; eng_score = '0;
    @(posedge clk); #1 eng_done = 1'b0;
    @(negedge clk);
    check_val("idle_eng_done_ignored", 32'(best_score), 32'(m_best_score));

    for (int r = 0; r < 4; r++) begin
      rand_scores(30);
      run_scan(-1, -1, -1, 1'b0);
    end

    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    one_seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (eng_start1) begin
        one_seen = 1;
        break;
      end
    end
    check_val("one_eng_start_seen", 32'(one_seen), 32'd1);
    check_val("one_offs", 32'({eng_row_off1, eng_col_off1}), 32'd0);
    @(posedge clk); #1 eng_done1 = 1'b1; eng_score1 = 16'd7;
    @(posedge clk); #1 eng_done1 = 1'b0;
    @(negedge clk);
    check_val("one_done", 32'(done1), 32'd1);
    check_val("one_best_score", 32'(best_score1), 32'd7);
    check_val("one_busy", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    check_val("one_eng_start_count", 32'(n_eng_start1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/match_scan_ctrl.md
Name: match_scan_ctrl

Overview:
- Sequencer for the mosaic block-matching engine in the stitching pipeline.
- Walks the POI window in raster order over every legal offset inside the ROI and issues one match request per offset.
- Collects each SAD score, tracks the minimum and reports the best offset with done/status.
- Drives the `status` level that the board top maps to LED0.

Parameters:
- ROI_DEPTH, 6, ROI rows.
- ROI_WIDTH, 6, ROI columns.
- POI_DEPTH, 4, POI rows; must be <= ROI_DEPTH, enforced by an elaboration error.
- POI_WIDTH, 4, POI columns; must be <= ROI_WIDTH, enforced by an elaboration error.
- SCORE_W, 16, width of the engine SAD score.
- TIMEOUT, 255, maximum cycles to wait for eng_done per offset; must be >= 1.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a scan
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when a scan completes normally
- status  out  1  high from scan completion until the next accepted start
- err  out  1  high after an engine timeout, until the next accepted start
- eng_start  out  1  one-cycle pulse to the match engine
- eng_row_off  out  RW  row offset for the request; RW = max(1, $clog2(ROI_DEPTH-POI_DEPTH+1))
- eng_col_off  out  CW  column offset for the request; CW = max(1, $clog2(ROI_WIDTH-POI_WIDTH+1))
- eng_done  in  1  one-cycle pulse from the engine; eng_score is valid in the same cycle
- eng_score  in  SCORE_W  SAD score for the current offset
- best_row  out  RW  row offset of the minimum score
- best_col  out  CW  column offset of the minimum score
- best_score  out  SCORE_W  minimum score found

Behaviour:
- Reset (async, takes effect immediately): state=IDLE; all outputs 0; row/col counters 0; internal timer 0.
- Offset ranges: row 0..ROI_DEPTH-POI_DEPTH, col 0..ROI_WIDTH-POI_WIDTH. The default parameters give 3x3 = 9 positions.
- FSM states: IDLE, ISSUE, WAIT, FIN, ERR.
- IDLE / ERR, on start:
  - Clear status and err; set busy=1.
  - Set row=col=0 and best_score = all ones.
  - Go to ISSUE.
- ISSUE:
  - eng_start=1 for exactly this cycle, with eng_row_off/eng_col_off equal to the current row/col.
  - timer=0; go to WAIT.
- WAIT, when eng_done=1:
  - If eng_score < best_score (strict), load best_score/best_row/best_col.
  - Ties keep the earlier raster position.
  - If at the last position, go to FIN. Otherwise col+1, wrapping to 0 with row+1, then go to ISSUE.
- WAIT, when eng_done=0:
  - timer+1.
  - If timer reaches TIMEOUT-1 without eng_done, go to ERR: err=1, busy=0. best_* hold partial results.
- Offset outputs hold during WAIT.
- FIN: done=1 for this single cycle; status=1 (held); busy=0; go to IDLE.
- Minimum cost per offset is 2 cycles (ISSUE, then WAIT with eng_done the next cycle). A 9-position scan with immediate eng_done completes in 18 cycles from start acceptance, plus the FIN cycle.
- start while busy: ignored, no effect.
- eng_done outside WAIT: ignored; score discarded.
- Single position (ROI==POI): one request at (0,0), then FIN.
- Reset mid-scan: immediate return to IDLE; eng_start drops; no done pulse is produced.
- best_* update only in WAIT and hold their values in IDLE, FIN and ERR.

Decomposition:
- Package mosaic_pkg holds:
  - state enum typedef;
  - offset-width constant functions (RW/CW derivation);
  - score typedef parameterised by SCORE_W, with SCORE_MAX as all ones.
- One sub-module, raster_offset_counter:
  - row/col counter with clear, advance and last flag;
  - parameterised by the number of rows and columns.

Test Plan:
- Default parameters; start; engine answers one cycle after each eng_start with scores 50,40,30,20,10,60,70,80,90 -> offsets issued in raster order (0,0)…(2,2); done after 9 requests; best=(1,1), score 10; status=1.
- Scores all 25 -> best=(0,0), best_score=25 (tie keeps first).
- Engine never answers at offset (0,1) -> err=1 exactly TIMEOUT cycles after that eng_start; busy=0; no done pulse; best=(0,0) from the first score. A new start clears err and rescans.
- Pulse start again during WAIT of position 3 -> no restart; scan completes normally with 9 eng_start pulses total.
- Assert reset during position 5 -> all outputs 0 immediately; a subsequent start scans from (0,0).
- ROI=POI=4x4, score 7 -> a single eng_start at (0,0); done; best_score=7.
